inst_rom_responder: RTL and testbench

- Memory-side responder for the core's instruction-fetch interface; the far end of the ce/addr/data fetch port driven by pc_reg.
- Holds the program in an internal word array, filled through a loader write port.
- Serves fetches with a programmable access latency and raises a stall request until the word is ready.
- A single-entry fetch buffer returns repeated addresses with no wait, so a stalled pipeline re-presenting the same PC sees no extra delay.

---
 rtl/inst_rom_responder.sv | 112 +++++++++++
 tb/tb_inst_rom_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: loader-filled word array serving core fetches
// with programmable latency, stall request and a single-entry fetch buffer.
module inst_rom_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_ce_i,
    input  logic [31:0]   rom_addr_i,
    output logic [31:0]   rom_data_o,
    output logic          stallreq_o,
    output logic          addr_err_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_data_i
);

    localparam bit BYPASS = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT =
        BYPASS ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        buf_valid_q;
    logic [31:0] buf_addr_q;
    logic [31:0] buf_data_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [AW-1:0] buf_idx;
    logic          misalign;
    logic          hit;
    logic          ld_pend;
    logic [31:0]   rd_word;

    assign idx      = rom_addr_i[AW+1:2];
    assign buf_idx  = buf_addr_q[AW+1:2];
    assign misalign = (rom_addr_i[1:0] != 2'b00);
    assign hit      = buf_valid_q && (buf_addr_q == rom_addr_i);
    assign ld_pend  = load_we_i && (load_addr_i == buf_idx);

    // A write landing on the capture edge must be the value captured.
    assign rd_word = (load_we_i && load_addr_i == idx) ? load_data_i : mem[idx];

    always_ff @(posedge clk) begin
        if (load_we_i) mem[load_addr_i] <= load_data_i;
    end

    always_comb begin
        rom_data_o = 32'd0;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;
        if (rst && rom_ce_i) begin
            if (misalign) begin
                addr_err_o = 1'b1;
            end else if (BYPASS) begin
                rom_data_o = mem[idx];
            end else if (state_q == IDLE && hit) begin
                rom_data_o = buf_data_q;
            end else begin
                stallreq_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 32'd0;
            buf_data_q  <= 32'd0;
        end else begin
            if (buf_valid_q && ld_pend) buf_data_q <= load_data_i;
            if (!rom_ce_i || misalign || BYPASS) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!hit) begin
                            state_q     <= BUSY;
                            cnt_q       <= CNT_INIT;
                            buf_addr_q  <= rom_addr_i;
                            buf_valid_q <= 1'b0;
                        end
                    end
                    BUSY: begin
                        if (rom_addr_i != buf_addr_q) begin
                            buf_addr_q <= rom_addr_i;
                            cnt_q      <= CNT_INIT;
                        end else if (cnt_q == 4'd0) begin
                            buf_data_q  <= rd_word;
                            buf_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else if (ld_pend) begin
                            cnt_q <= CNT_INIT;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench for inst_rom_responder: one instance at WAIT_CYCLES=2,
// one at WAIT_CYCLES=0, sharing all inputs.
module tb_inst_rom_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [9:0]  la = 10'd0;
    logic [31:0] ld = 32'd0;

    logic [31:0] d0, d1;
    logic        s0, s1, e0, e1;

    inst_rom_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
        .rom_data_o(d0), .stallreq_o(s0), .addr_err_o(e0),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
    );

    inst_rom_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
        .rom_data_o(d1), .stallreq_o(s1), .addr_err_o(e1),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [31:0] data;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int nvec = 0;
    int nerr = 0;

    logic        rst_nx = 1'b0;
    logic        we_nx = 1'b0;
    logic [9:0]  la_nx = 10'd0;
    logic [31:0] ld_nx = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input bit sel, input logic c,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic st, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = rst_nx;
        we    = we_nx;
        la    = la_nx;
        ld    = ld_nx;
        we_nx = 1'b0;
        ce    = c;
        addr  = a;
        e.tag = tag;
        e.sel = sel;
        e.data = d;
        e.stall = st;
        e.err = er;
        sb.push_back(e);
    endtask

    task automatic load(input logic [9:0] i, input logic [31:0] v);
        we_nx = 1'b1;
        la_nx = i;
        ld_nx = v;
        cyc("load", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic stall(input string tag, input logic [31:0] a, input int n);
        for (int k = 0; k < n; k++)
            cyc(tag, 1'b0, 1'b1, a, 32'd0, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.sel) begin
                chk({e.tag, ".data"}, d1, e.data);
                chk({e.tag, ".stall"}, {31'd0, s1}, {31'd0, e.stall});
                chk({e.tag, ".err"}, {31'd0, e1}, {31'd0, e.err});
            end else begin
                chk({e.tag, ".data"}, d0, e.data);
                chk({e.tag, ".stall"}, {31'd0, s0}, {31'd0, e.stall});
                chk({e.tag, ".err"}, {31'd0, e0}, {31'd0, e.err});
            end
        end
    end

    initial begin
        cyc("rst.w2", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc("rst.w0", 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_nx = 1'b1;

        load(10'd0, 32'h3401_0020);
        load(10'd1, 32'h1111_1111);
        load(10'd2, 32'h2222_2222);
        load(10'd4, 32'hDEAD_BEEF);
        load(10'd16, 32'h1234_5678);
        load(10'd5, 32'hAAAA_AAAA);
        load(10'd7, 32'h7777_7777);

        stall("miss0", 32'h0, 3);
        for (int k = 0; k < 3; k++)
            cyc("hit0", 1'b0, 1'b1, 32'h0, 32'h3401_0020, 1'b0, 1'b0);

        stall("miss4", 32'h4, 3);
        cyc("hit4", 1'b0, 1'b1, 32'h4, 32'h1111_1111, 1'b0, 1'b0);
        stall("miss8", 32'h8, 3);
        cyc("hit8", 1'b0, 1'b1, 32'h8, 32'h2222_2222, 1'b0, 1'b0);

        stall("redir10", 32'h10, 1);
        stall("redir40", 32'h40, 3);
        cyc("hit40", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0);

        cyc("misal", 1'b0, 1'b1, 32'h6, 32'h0, 1'b0, 1'b1);
        cyc("ce0", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        cyc("keep40", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0);

        stall("miss14", 32'h14, 3);
        cyc("hit14", 1'b0, 1'b1, 32'h14, 32'hAAAA_AAAA, 1'b0, 1'b0);
        we_nx = 1'b1;
        la_nx = 10'd5;
        ld_nx = 32'hBBBB_BBBB;
        cyc("coh.wr", 1'b0, 1'b1, 32'h14, 32'hAAAA_AAAA, 1'b0, 1'b0);
        cyc("coh.new", 1'b0, 1'b1, 32'h14, 32'hBBBB_BBBB, 1'b0, 1'b0);

        stall("miss1c", 32'h1C, 1);
        rst_nx = 1'b0;
        cyc("rstbusy", 1'b0, 1'b1, 32'h1C, 32'h0, 1'b0, 1'b0);
        rst_nx = 1'b1;
        stall("remiss1c", 32'h1C, 3);
        cyc("hit1c", 1'b0, 1'b1, 32'h1C, 32'h7777_7777, 1'b0, 1'b0);

        cyc("w0.a0", 1'b1, 1'b1, 32'h0, 32'h3401_0020, 1'b0, 1'b0);
        cyc("w0.a4", 1'b1, 1'b1, 32'h4, 32'h1111_1111, 1'b0, 1'b0);
        cyc("w0.a40", 1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0);
        cyc("w0.a14", 1'b1, 1'b1, 32'h14, 32'hBBBB_BBBB, 1'b0, 1'b0);
        cyc("w0.wrap", 1'b1, 1'b1, 32'h1004, 32'h1111_1111, 1'b0, 1'b0);
        cyc("w0.misal", 1'b1, 1'b1, 32'h2, 32'h0, 1'b0, 1'b1);
        cyc("w0.ce0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) chk("sb.drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
